// File: rtl/pixel_mixer_if.sv
// Tile-engine prep/pixel handshake, palette lookup and scanline-buffer write bus
// between the pixel mixer (master) and its surrounding tile engines / RAMs (slave).
interface pixel_mixer_if;
  logic        line_start;
  logic        bg_prep;
  logic        fg_prep;
  logic        bg_done;
  logic        fg_done;
  logic [8:0]  pixel_addr;
  logic [7:0]  bg_pixel_data;
  logic [7:0]  fg_pixel_data;
  logic [7:0]  pal_addr;
  logic [23:0] pal_rddata;
  logic [8:0]  lb_addr;
  logic [23:0] lb_wrdata;
  logic        lb_wren;
  logic        busy;
  logic        mix_done;

  modport master (
    input  line_start, bg_done, fg_done, bg_pixel_data, fg_pixel_data, pal_rddata,
    output bg_prep, fg_prep, pixel_addr, pal_addr, lb_addr, lb_wrdata, lb_wren, busy, mix_done
  );

  modport slave (
    output line_start, bg_done, fg_done, bg_pixel_data, fg_pixel_data, pal_rddata,
    input  bg_prep, fg_prep, pixel_addr, pal_addr, lb_addr, lb_wrdata, lb_wren, busy, mix_done
  );
endinterface

// File: rtl/pixel_mixer.sv
// Per-scanline compositor: preps both tile engines, sweeps pixel_addr across the row and
// writes foreground-over-background palette colours into the scanline buffer.
module pixel_mixer #(
  parameter int unsigned NUM_PIXELS = 320,
  parameter logic [7:0]  BACKDROP   = 8'h00
) (
  input  logic          clk,
  input  logic          rst_n,
  pixel_mixer_if.master bus
);

  typedef enum logic [1:0] {IDLE, PREP, MIX, DRAIN} state_t;

  localparam logic [8:0] LAST_ADDR = 9'(NUM_PIXELS - 1);

  state_t     state;
  state_t     state_nx;
  logic       prep_q;
  logic       bg_seen;
  logic       fg_seen;
  logic       both_done;
  logic       last_write;
  logic       s1_valid;
  logic [8:0] s1_addr;
  logic       s2_valid;
  logic [8:0] s2_addr;
  logic [7:0] sel;

  // A done arriving on the same cycle as the other latched one completes PREP immediately.
  assign both_done  = (bg_seen | bus.bg_done) & (fg_seen | bus.fg_done);
  assign last_write = bus.lb_wren && (bus.lb_addr == LAST_ADDR);

  assign bus.bg_prep   = prep_q;
  assign bus.fg_prep   = prep_q;
  assign bus.busy      = (state != IDLE);
  assign bus.lb_wrdata = bus.pal_rddata;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_nx = state;
    unique case (state)
      IDLE:    if (bus.line_start)              state_nx = PREP;
      PREP:    if (both_done)                   state_nx = MIX;
      MIX:     if (bus.pixel_addr == LAST_ADDR) state_nx = DRAIN;
      DRAIN:   if (last_write)                  state_nx = IDLE;
      default:                                  state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prep_q         <= 1'b0;
      bg_seen        <= 1'b0;
      fg_seen        <= 1'b0;
      bus.pixel_addr <= '0;
      bus.mix_done   <= 1'b0;
    end else begin
      prep_q       <= (state == IDLE) && bus.line_start;
      bus.mix_done <= (state == DRAIN) && last_write;
      if (state == PREP) begin
        bg_seen <= bg_seen | bus.bg_done;
        fg_seen <= fg_seen | bus.fg_done;
      end else begin
        bg_seen <= 1'b0;
        fg_seen <= 1'b0;
      end
      if ((state == MIX) && (bus.pixel_addr != LAST_ADDR)) bus.pixel_addr <= bus.pixel_addr + 9'd1;
      else                                                 bus.pixel_addr <= '0;
    end
  end

  // Foreground wins unless its colour nibble is transparent; the palette nibble rides along.
  always_comb begin
    sel = BACKDROP;
    if (bus.fg_pixel_data[3:0] != 4'h0)      sel = bus.fg_pixel_data;
    else if (bus.bg_pixel_data[3:0] != 4'h0) sel = bus.bg_pixel_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid    <= 1'b0;
      s1_addr     <= '0;
      s2_valid    <= 1'b0;
      s2_addr     <= '0;
      bus.pal_addr <= '0;
      bus.lb_wren <= 1'b0;
      bus.lb_addr <= '0;
    end else begin
      s1_valid    <= (state == MIX);
      s1_addr     <= bus.pixel_addr;
      s2_valid    <= s1_valid && (state != IDLE);
      bus.lb_wren <= s2_valid && (state != IDLE);
      if (s1_valid) begin
        bus.pal_addr <= sel;
        s2_addr      <= s1_addr;
      end
      if (s2_valid) bus.lb_addr <= s2_addr;
    end
  end

endmodule

// File: tb/tb_pixel_mixer.sv
// Bench for pixel_mixer: tile-engine and palette models, a write scoreboard, a priority
// vector table and hand-written sequences for done skew, busy pulses, reset and back-to-back rows.
module tb_pixel_mixer;

  localparam int         NUM      = 320;
  localparam logic [7:0] BACKDROP = 8'h00;

  typedef struct {
    logic [8:0] x;
    logic [7:0] fg;
    logic [7:0] bg;
    logic [7:0] exp;
  } vec_t;

  typedef struct {
    logic [8:0] x;
    logic [7:0] pal;
  } sb_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   mode = 0;

  vec_t       vecs[8];
  sb_t        sb[$];
  logic [7:0] pal_seen[512];
  logic [7:0] prev_pal = 8'h00;
  int         bg_prep_cnt = 0;
  int         fg_prep_cnt = 0;
  int         mix_done_cnt = 0;
  int         mix_done_cyc = 0;
  int         mix_start_cyc = 0;
  int         max_addr = 0;

  pixel_mixer_if bus ();

  pixel_mixer #(.NUM_PIXELS(NUM), .BACKDROP(BACKDROP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] tile_fg(input logic [8:0] x);
    if (mode == 0) return 8'h00;
    for (int i = 0; i < 8; i++) if (vecs[i].x == x) return vecs[i].fg;
    return x[7:0] & {4'hF, {4{x[0]}}};
  endfunction

  function automatic logic [7:0] tile_bg(input logic [8:0] x);
    if (mode == 0) return {4'h2, x[3:0] | 4'h1};
    for (int i = 0; i < 8; i++) if (vecs[i].x == x) return vecs[i].bg;
    return {x[8:5], x[3:0] & {4{x[1]}}};
  endfunction

  function automatic logic [7:0] exp_sel(input logic [7:0] fg, input logic [7:0] bg);
    if (fg[3:0] != 4'h0) return fg;
    if (bg[3:0] != 4'h0) return bg;
    return BACKDROP;
  endfunction

  function automatic logic [23:0] pal_fn(input logic [7:0] a);
    return {a, ~a, a ^ 8'h3C};
  endfunction

  // Tile engines and palette RAM: registered one-cycle responses.
  always @(posedge clk) begin
    bus.bg_pixel_data <= tile_bg(bus.pixel_addr);
    bus.fg_pixel_data <= tile_fg(bus.pixel_addr);
    bus.pal_rddata    <= pal_fn(bus.pal_addr);
  end

  // Output monitor and scoreboard.
  always @(negedge clk) begin
    if (bus.bg_prep === 1'b1) bg_prep_cnt++;
    if (bus.fg_prep === 1'b1) fg_prep_cnt++;
    if (bus.mix_done === 1'b1) begin
      mix_done_cnt++;
      mix_done_cyc = cyc;
    end
    if (bus.pixel_addr === 9'd1) mix_start_cyc = cyc - 1;
    if (rst_n && int'(bus.pixel_addr) > max_addr) max_addr = int'(bus.pixel_addr);
    if (bus.lb_wren === 1'b1) begin
      if (sb.size() == 0) begin
        check("lb_wren_stray", {31'd0, bus.lb_wren}, 32'd0);
      end else begin
        sb_t e;
        e = sb.pop_front();
        check("lb_addr", {23'd0, bus.lb_addr}, {23'd0, e.x});
        check("pal_addr", {24'd0, prev_pal}, {24'd0, e.pal});
        check("lb_wrdata", {8'd0, bus.lb_wrdata}, {8'd0, pal_fn(e.pal)});
        pal_seen[e.x] = prev_pal;
      end
    end
    prev_pal = bus.pal_addr;
  end

  task automatic push_row();
    sb_t e;
    for (int x = 0; x < NUM; x++) begin
      e.x   = 9'(x);
      e.pal = exp_sel(tile_fg(9'(x)), tile_bg(9'(x)));
      sb.push_back(e);
    end
  endtask

  // Starts at a negedge; returns #1 after the negedge of the mix_done cycle.
  task automatic run_row(input int mode_i, input int bd, input int fd, input bit poke);
    int  p;
    int  done0;
    int  bgp0;
    int  fgp0;
    bit  seen;
    mode = mode_i;
    push_row();
    done0    = mix_done_cnt;
    bgp0     = bg_prep_cnt;
    fgp0     = fg_prep_cnt;
    max_addr = 0;
    bus.line_start = 1'b1;
    @(negedge clk);
    p = cyc;
    bus.line_start = 1'b0;
    check("bg_prep_pulse", {31'd0, bus.bg_prep}, 32'd1);
    check("fg_prep_pulse", {31'd0, bus.fg_prep}, 32'd1);
    check("busy_in_prep", {31'd0, bus.busy}, 32'd1);
    seen = 1'b0;
    for (int t = 0; t < 1000; t++) begin
      if (t > 0) @(negedge clk);
      if (bus.mix_done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      bus.bg_done    = (t == bd);
      bus.fg_done    = (t == fd);
      bus.line_start = poke && (t == 2 || t == 60);
    end
    bus.bg_done    = 1'b0;
    bus.fg_done    = 1'b0;
    bus.line_start = 1'b0;
    #1;
    check("row_finished", {31'd0, seen}, 32'd1);
    check("mix_start", mix_start_cyc, p + ((bd > fd) ? bd : fd) + 1);
    check("mix_done_latency", mix_done_cyc - mix_start_cyc, 323);
    check("mix_done_count", mix_done_cnt - done0, 1);
    check("bg_prep_count", bg_prep_cnt - bgp0, 1);
    check("fg_prep_count", fg_prep_cnt - fgp0, 1);
    check("writes_left", sb.size(), 0);
    check("max_pixel_addr", max_addr, NUM - 1);
    check("busy_at_mix_done", {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    int  done0;
    bit  hit;
    vecs[0] = '{x: 9'd10, fg: 8'h35, bg: 8'h17, exp: 8'h35};
    vecs[1] = '{x: 9'd11, fg: 8'h30, bg: 8'h17, exp: 8'h17};
    vecs[2] = '{x: 9'd12, fg: 8'h30, bg: 8'h10, exp: BACKDROP};
    vecs[3] = '{x: 9'd13, fg: 8'h00, bg: 8'h00, exp: BACKDROP};
    vecs[4] = '{x: 9'd14, fg: 8'hF1, bg: 8'h00, exp: 8'hF1};
    vecs[5] = '{x: 9'd15, fg: 8'h00, bg: 8'hA8, exp: 8'hA8};
    vecs[6] = '{x: 9'd16, fg: 8'h0F, bg: 8'hF0, exp: 8'h0F};
    vecs[7] = '{x: 9'd17, fg: 8'h40, bg: 8'h03, exp: 8'h03};

    bus.line_start = 1'b0;
    bus.bg_done    = 1'b0;
    bus.fg_done    = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_bg_prep", {31'd0, bus.bg_prep}, 32'd0);
    check("rst_fg_prep", {31'd0, bus.fg_prep}, 32'd0);
    check("rst_lb_wren", {31'd0, bus.lb_wren}, 32'd0);
    check("rst_mix_done", {31'd0, bus.mix_done}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_pixel_addr", {23'd0, bus.pixel_addr}, 32'd0);
    check("rst_pal_addr", {24'd0, bus.pal_addr}, 32'd0);
    check("rst_lb_addr", {23'd0, bus.lb_addr}, 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Basic row, then done skew both ways.
    run_row(0, 5, 5, 1'b0);
    repeat (4) @(negedge clk);
    run_row(0, 3, 40, 1'b0);
    repeat (4) @(negedge clk);
    run_row(1, 0, 0, 1'b0);

    // Priority table against the pal_addr captured for each listed pixel.
    for (int i = 0; i < 8; i++)
      check($sformatf("prio_x%0d", vecs[i].x), {24'd0, pal_seen[vecs[i].x]}, {24'd0, vecs[i].exp});

    // line_start pulses while busy are dropped.
    repeat (4) @(negedge clk);
    run_row(1, 5, 5, 1'b1);
    repeat (6) @(negedge clk);

    // Reset mid-MIX aborts the row.
    mode = 0;
    push_row();
    bus.line_start = 1'b1;
    @(negedge clk);
    bus.line_start = 1'b0;
    bus.bg_done    = 1'b1;
    bus.fg_done    = 1'b1;
    @(negedge clk);
    bus.bg_done = 1'b0;
    bus.fg_done = 1'b0;
    hit = 1'b0;
    for (int t = 0; t < 400; t++) begin
      if (bus.pixel_addr === 9'd100) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("reached_addr_100", {31'd0, hit}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_bg_prep", {31'd0, bus.bg_prep}, 32'd0);
    check("mid_rst_lb_wren", {31'd0, bus.lb_wren}, 32'd0);
    check("mid_rst_mix_done", {31'd0, bus.mix_done}, 32'd0);
    check("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    check("mid_rst_pixel_addr", {23'd0, bus.pixel_addr}, 32'd0);
    check("mid_rst_pal_addr", {24'd0, bus.pal_addr}, 32'd0);
    check("mid_rst_lb_addr", {23'd0, bus.lb_addr}, 32'd0);
    #1;
    check("writes_before_reset", sb.size(), NUM - 98);
    sb.delete();
    rst_n = 1'b1;
    done0 = mix_done_cnt;
    repeat (30) @(negedge clk);
    check("no_mix_done_after_reset", mix_done_cnt - done0, 0);
    check("idle_after_reset", {31'd0, bus.busy}, 32'd0);
    run_row(0, 5, 5, 1'b0);

    // Back-to-back: second line_start lands in the mix_done cycle.
    repeat (3) @(negedge clk);
    run_row(0, 5, 5, 1'b0);
    run_row(1, 2, 9, 1'b0);
    repeat (10) @(negedge clk);
    check("final_writes_left", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pixel_mixer.md
# pixel_mixer

Initiator side of the tile-engine prep/pixel handshake. Per scanline it issues `prep` to the background and foreground tile engines and waits for both `done` pulses. It then sweeps a shared `pixel_addr` across the visible row and composites the two 8-bit pixel streams (foreground over background). The winning palette entry is resolved through palette RAM and written as a 24-bit colour into the scanline buffer consumed by video output.

## Interface
Parameters:
- `NUM_PIXELS`, 320: visible pixels per row; `pixel_addr` sweeps 0..`NUM_PIXELS`-1.
- `BACKDROP`, 8'h00: palette address used when both layers are transparent.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `line_start` in 1: one-cycle request from ppu_logic to build the next row.
- `bg_prep` out 1: prep pulse to BG tile engine.
- `fg_prep` out 1: prep pulse to FG tile engine.
- `bg_done` in 1: BG tile engine done pulse.
- `fg_done` in 1: FG tile engine done pulse.
- `pixel_addr` out 9: shared pixel index to both tile engines.
- `bg_pixel_data` in 8: BG {palette[3:0], colour[3:0]}, valid 1 cycle after `pixel_addr`.
- `fg_pixel_data` in 8: FG {palette[3:0], colour[3:0]}, valid 1 cycle after `pixel_addr`.
- `pal_addr` out 8: palette RAM read address (registered).
- `pal_rddata` in 24: palette RAM data, 1-cycle read latency.
- `lb_addr` out 9: scanline buffer write address.
- `lb_wrdata` out 24: scanline buffer write data (wired from `pal_rddata`).
- `lb_wren` out 1: scanline buffer write enable.
- `busy` out 1: high in every state except IDLE.
- `mix_done` out 1: one-cycle pulse when the row is fully written.

## Operation
- States: IDLE, PREP, MIX, DRAIN.
- **IDLE**
  - `line_start`=1 → PREP.
  - `bg_prep` and `fg_prep` are high together for exactly the first cycle of PREP.
  - Both done-latches are cleared on this entry.
- **PREP**
  - `bg_done` and `fg_done` are latched independently. They may arrive in any order, the same cycle, or the same cycle as `*_prep`.
  - When both latches are set (including the cycle the second done arrives), → MIX with `pixel_addr`=0.
  - There is no timeout.
- **MIX**
  - `pixel_addr` increments by 1 per cycle.
  - On the cycle `pixel_addr`=`NUM_PIXELS`-1 → DRAIN.
  - Outside MIX, `pixel_addr` holds 0.
- **Select stage** (cycle after an address is issued):
  - If `fg_pixel_data[3:0]`≠0, select the FG byte.
  - Else if `bg_pixel_data[3:0]`≠0, select the BG byte.
  - Else select `BACKDROP`.
  - The selected 8-bit value is registered into `pal_addr`.
- **Write stage**: `lb_wren`=1 and `lb_addr`=x, registered to align with `pal_rddata` for pixel x.
- **DRAIN**
  - Lasts until the write for pixel `NUM_PIXELS`-1 completes.
  - `mix_done` pulses on the cycle after that write; state → IDLE on the same edge.
- `line_start` outside IDLE is ignored (dropped, not queued).
- Pixel data sampled in any state other than the select stage of a valid pipeline slot is ignored.
- Pipeline valid bits are cleared in IDLE, so there are no stray `lb_wren` pulses.

## Timing
- Reset values (`rst_n`=0 at a clock edge):
  - state IDLE.
  - `bg_prep`/`fg_prep`/`lb_wren`/`mix_done`/`busy` = 0.
  - `pixel_addr`=0, `pal_addr`=0, `lb_addr`=0.
  - Done-latches and pipeline valids cleared.
- Reset mid-MIX or mid-DRAIN aborts the row immediately: no further `lb_wren` and no `mix_done`.
- `line_start` sampled at edge k → PREP during cycle k+1, with `*_prep`=1 in cycle k+1 only.
- Second done seen at edge m → `pixel_addr`=0 in cycle m+1.
- Pixel x issued in cycle c:
  - tile data valid in c+1;
  - `pal_addr` valid in c+2;
  - `lb_wren`/`lb_addr`=x/`lb_wrdata` valid in c+3.
- Address-to-write latency: 3 cycles.
- Throughput: 1 pixel/cycle, no bubbles.
- For `NUM_PIXELS`=320, first address in cycle c0:
  - last write in c0+322;
  - `mix_done` in c0+323;
  - IDLE in c0+323;
  - `busy` falls in c0+323.
- A new `line_start` is accepted in the `mix_done` cycle at the earliest.
- Width rules:
  - `pixel_addr` is 9 bits and never exceeds `NUM_PIXELS`-1.
  - The transparency test uses only bits [3:0].
  - The palette nibble is carried unmodified.

## Test plan
- Basic row:
  - Stimulus: `line_start`; both dones 5 cycles later; BG returns {4'h2, x[3:0]|1}, FG returns 0.
  - Required: 320 writes with `lb_addr` 0..319 in order; `pal_addr`=8'h2_(x[3:0]|1); `mix_done` exactly 323 cycles after `pixel_addr`=0.
- Done skew:
  - Stimulus (a): `bg_done` at +3, `fg_done` at +40.
  - Stimulus (b): both dones in the same cycle as the prep.
  - Required: MIX begins the cycle after the later done in both cases.
- Priority:
  - Stimulus: x=10 FG=8'h35, BG=8'h17; x=11 FG=8'h30, BG=8'h17; x=12 FG=8'h30, BG=8'h10.
  - Required: `pal_addr` 8'h35, 8'h17, `BACKDROP` respectively.
- Busy ignore:
  - Stimulus: `line_start` pulses during PREP and MIX.
  - Required: no extra `*_prep`, the row completes unchanged, exactly one `mix_done`.
- Reset mid-MIX:
  - Stimulus: `rst_n`=0 at `pixel_addr`=100.
  - Required: all outputs at reset values next cycle, no further `lb_wren`, no `mix_done`; a subsequent `line_start` produces a full clean row.
- Back-to-back:
  - Stimulus: `line_start` in the `mix_done` cycle.
  - Required: `*_prep` the next cycle; second row writes all 320 pixels.
